iob_fifo_sync_ram_ctrl: RTL and testbench
=========================================

Name: iob_fifo_sync_ram_ctrl

Overview:
- Synchronous FIFO controller that drives an external two-port RAM (one write port, one registered read port, 1-cycle read latency, no reset on contents).
- Owns write/read pointers, occupancy level and full/empty flags; the RAM holds the data.
- Sits directly upstream of the RAM; the parent wires the ext_mem_* ports to the RAM ports with the same DATA_W/ADDR_W.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_W

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
w_en  input  1  push request
w_data  input  DATA_W  push data
w_full  output  1  FIFO full, push ignored
r_en  input  1  pop request
r_data  output  DATA_W  popped data, valid when r_valid=1
r_valid  output  1  r_data holds the word popped in the previous cycle
r_empty  output  1  FIFO empty, pop ignored
level  output  ADDR_W+1  current occupancy, 0..DEPTH
ext_mem_w_en  output  1  RAM write enable
ext_mem_w_addr  output  ADDR_W  RAM write address
ext_mem_w_data  output  DATA_W  RAM write data
ext_mem_r_en  output  1  RAM read enable
ext_mem_r_addr  output  ADDR_W  RAM read address
ext_mem_r_data  input  DATA_W  RAM registered read data

Behaviour:
- Reset, sampled on rising edge with rst_n=0: wptr=0, rptr=0, level=0, r_valid=0, so r_empty=1 and w_full=0. RAM contents are not cleared. A pop accepted in the reset cycle is discarded: r_valid=0 on the next cycle.
- Flags:
  - w_full = (level==DEPTH); r_empty = (level==0).
  - Both decode the registered level; neither has a combinational path from w_en or r_en.
- Accept rules:
  - push_ok = w_en & ~w_full; pop_ok = r_en & ~r_empty.
  - Requests that are not accepted are silently dropped: no pointer, level or RAM activity.
- Write path (combinational):
  - ext_mem_w_en = push_ok, ext_mem_w_addr = wptr, ext_mem_w_data = w_data.
  - wptr increments on push_ok and wraps naturally modulo DEPTH.
- Read path (combinational):
  - ext_mem_r_en = pop_ok, ext_mem_r_addr = rptr.
  - rptr increments on pop_ok and wraps modulo DEPTH.
- Read latency:
  - r_valid is registered and equals pop_ok of the previous cycle.
  - r_data = ext_mem_r_data, passed through directly.
  - Popped data is therefore presented exactly 1 cycle after an accepted pop.
  - r_data holds its last value while no pop occurs, because the RAM holds its output.
- Level update:
  - push only: +1. Pop only: -1. Both or neither: unchanged.
  - Arithmetic is ADDR_W+1 bits; level never exceeds DEPTH and never goes below 0, by construction of the accept rules.
- Simultaneous push and pop:
  - Empty: only the push is accepted; the pop is dropped. There is no write-through bypass, so the word becomes poppable the following cycle.
  - Full: only the pop is accepted; the push is dropped even though a slot frees this cycle.
  - Otherwise: both are accepted and level is unchanged.
- Address collision: an accepted read and write never target the same address in the same cycle.
  - When 0<level<DEPTH, rptr != wptr.
  - At the boundaries, one of the two operations is blocked.
  - No read-during-write policy is therefore required of the RAM.
- Back-to-back pops every cycle are supported, giving a throughput of 1 word/cycle.

Test Plan:
All scenarios use ADDR_W=2 (DEPTH=4), DATA_W=8, driven by the controller connected to a behavioural 2p RAM.
1. Reset: hold rst_n=0 for 2 cycles with w_en=r_en=1 -> r_empty=1, w_full=0, level=0, r_valid=0, ext_mem_w_en=ext_mem_r_en=0 throughout.
2. Fill then overflow: push 0x11,0x22,0x33,0x44, then 0x55 -> level 1,2,3,4; w_full=1 after the 4th push; the 5th push is dropped (ext_mem_w_en=0); level stays 4.
3. Drain: from (2), pop 5 consecutive cycles -> r_valid=1 with r_data 0x11,0x22,0x33,0x44 one cycle after each pop; the 5th pop is dropped (r_valid=0 next cycle); r_empty=1, level=0.
4. Wrap: push/pop 10 words 0xA0..0xA9, keeping level ≤2 -> pointers wrap past 3 to 0; output order is exactly 0xA0..0xA9 with no loss.
5. Simultaneous push and pop: when empty -> level 0→1, no r_valid; at level 2 -> level stays 2 and FIFO order is preserved; when full -> level 4→3, w_data discarded.
6. Mid-operation reset: with level=3 and a pop accepted, assert rst_n=0 for 1 cycle -> next cycle r_valid=0, level=0, r_empty=1; a subsequent push of 0x77 and pop returns 0x77 from address 0.

Source files
------------

// File: rtl/iob_fifo_sync_ram_ctrl.sv
// Synchronous FIFO controller for an external two-port RAM with a registered read port.
// Owns the pointers, occupancy level and flags; the RAM holds the data words.
module iob_fifo_sync_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_empty,
  output logic [ADDR_W:0]   level,
  output logic              ext_mem_w_en,
  output logic [ADDR_W-1:0] ext_mem_w_addr,
  output logic [DATA_W-1:0] ext_mem_w_data,
  output logic              ext_mem_r_en,
  output logic [ADDR_W-1:0] ext_mem_r_addr,
  input  logic [DATA_W-1:0] ext_mem_r_data
);

  localparam int               DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  ONE_L   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  logic [ADDR_W-1:0] wptr_p0;
  logic [ADDR_W-1:0] rptr_p0;
  logic [ADDR_W:0]   level_p0;
  logic              vld_p1;
  logic              push_ok;
  logic              pop_ok;

  function automatic logic [ADDR_W:0] level_next(
    input logic [ADDR_W:0] lvl,
    input logic            push,
    input logic            pop
  );
    logic [ADDR_W:0] res;
    res = lvl;
    if (push && !pop)      res = lvl + ONE_L;
    else if (pop && !push) res = lvl - ONE_L;
    return res;
  endfunction

  assign w_full  = (level_p0 == DEPTH_L);
  assign r_empty = (level_p0 == '0);
  assign level   = level_p0;

  // Requests in a reset cycle must not reach the RAM or the pointers.
  assign push_ok = rst_n & w_en & ~w_full;
  assign pop_ok  = rst_n & r_en & ~r_empty;

  assign ext_mem_w_en   = push_ok;
  assign ext_mem_w_addr = wptr_p0;
  assign ext_mem_w_data = w_data;
  assign ext_mem_r_en   = pop_ok;
  assign ext_mem_r_addr = rptr_p0;

  // Stage p0 -> p1: pointer/level update and read-valid alignment with RAM latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_p0  <= '0;
      rptr_p0  <= '0;
      level_p0 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      if (push_ok) wptr_p0 <= wptr_p0 + ONE_A;
      if (pop_ok)  rptr_p0 <= rptr_p0 + ONE_A;
      level_p0 <= level_next(level_p0, push_ok, pop_ok);
      vld_p1   <= pop_ok;
    end
  end

  assign r_valid = vld_p1;
  assign r_data  = ext_mem_r_data;

endmodule

// File: tb/tb_iob_fifo_sync_ram_ctrl.sv
// Bench for iob_fifo_sync_ram_ctrl with a behavioural 2-port RAM and a queue-based FIFO model.
module tb_iob_fifo_sync_ram_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic              r_en;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_empty;
  logic [ADDR_W:0]   level;
  logic              ext_mem_w_en;
  logic [ADDR_W-1:0] ext_mem_w_addr;
  logic [DATA_W-1:0] ext_mem_w_data;
  logic              ext_mem_r_en;
  logic [ADDR_W-1:0] ext_mem_r_addr;
  logic [DATA_W-1:0] ext_mem_r_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] q[$];
  logic              exp_valid;
  logic [DATA_W-1:0] exp_data;
  int                wcnt;
  int                rcnt;

  logic [DATA_W-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  iob_fifo_sync_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_en(w_en), .w_data(w_data), .w_full(w_full),
    .r_en(r_en), .r_data(r_data), .r_valid(r_valid), .r_empty(r_empty),
    .level(level),
    .ext_mem_w_en(ext_mem_w_en), .ext_mem_w_addr(ext_mem_w_addr), .ext_mem_w_data(ext_mem_w_data),
    .ext_mem_r_en(ext_mem_r_en), .ext_mem_r_addr(ext_mem_r_addr), .ext_mem_r_data(ext_mem_r_data)
  );

  always @(posedge clk) begin
    if (ext_mem_w_en) mem[ext_mem_w_addr] <= ext_mem_w_data;
    if (ext_mem_r_en) ext_mem_r_data <= mem[ext_mem_r_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model on the rising edge.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic rn);
    bit push_exp, pop_exp;
    int sz;
    w_en = w; w_data = d; r_en = r; rst_n = rn;
    @(negedge clk);
    sz = q.size();
    push_exp = rn && w && (sz < DEPTH);
    pop_exp  = rn && r && (sz > 0);
    chk("level",   32'(level),   32'(sz));
    chk("w_full",  32'(w_full),  32'(sz == DEPTH));
    chk("r_empty", 32'(r_empty), 32'(sz == 0));
    chk("r_valid", 32'(r_valid), 32'(exp_valid));
    if (exp_valid) chk("r_data", 32'(r_data), 32'(exp_data));
    chk("mem_w_en", 32'(ext_mem_w_en), 32'(push_exp));
    chk("mem_r_en", 32'(ext_mem_r_en), 32'(pop_exp));
    if (push_exp) begin
      chk("mem_w_addr", 32'(ext_mem_w_addr), 32'(wcnt % DEPTH));
      chk("mem_w_data", 32'(ext_mem_w_data), 32'(d));
    end
    if (pop_exp) chk("mem_r_addr", 32'(ext_mem_r_addr), 32'(rcnt % DEPTH));
    if (!rn) begin
      q.delete();
      exp_valid = 1'b0;
      wcnt = 0;
      rcnt = 0;
    end else begin
      exp_valid = pop_exp;
      if (pop_exp) begin
        exp_data = q.pop_front();
        rcnt++;
      end
      if (push_exp) begin
        q.push_back(d);
        wcnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_valid = 1'b0; exp_data = '0; wcnt = 0; rcnt = 0;
    rst_n = 1'b0; w_en = 1'b1; r_en = 1'b1; w_data = 8'h5A;
    @(posedge clk);
    #1;

    // Reset held with requests active
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);

    // Fill then overflow
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b1);

    // Drain with one extra pop
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap with level kept at 1
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hA0 + i), (i > 0), 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous push/pop: empty, level 2, full
    step(1'b1, 8'hB0, 1'b1, 1'b1);
    step(1'b1, 8'hB1, 1'b0, 1'b1);
    step(1'b1, 8'hB2, 1'b1, 1'b1);
    step(1'b1, 8'hB3, 1'b0, 1'b1);
    step(1'b1, 8'hB4, 1'b0, 1'b1);
    step(1'b1, 8'hBF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

    // Mid-operation reset, then reuse from address 0
    step(1'b1, 8'hC0, 1'b0, 1'b1);
    step(1'b1, 8'hC1, 1'b0, 1'b1);
    step(1'b1, 8'hC2, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic with rare resets
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
